counter_timer_chain: RTL and testbench



---
 rtl/counter_timer_pkg.sv | 29 ++
 rtl/counter_timer_core.sv | 54 +++++
 rtl/counter_timer_chain.sv | 132 +++++++++++++
 tb/tb_counter_timer_chain.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_timer_pkg.sv
// Shared constants and helpers for the counter/timer peripheral.
package counter_timer_pkg;

  // Config register bit positions
  localparam int CFG_EN      = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_UP      = 2;
  localparam int CFG_CHAIN   = 3;
  localparam int CFG_IRQEN   = 4;
  localparam int CFG_BITS    = 5;

  // Register offsets inside the 3-word window
  localparam logic [7:0] OFF_CFG = 8'h00;
  localparam logic [7:0] OFF_VAL = 8'h04;
  localparam logic [7:0] OFF_DAT = 8'h08;

  // Merge a bus write into an existing word, one byte lane per strobe bit
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/counter_timer_core.sv
// Counting engine: holds the count value and enable bit, decides when a
// tick happens and whether it is a terminal count.
module counter_timer_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mode_oneshot,
  input  logic        mode_up,
  input  logic        mode_chain,
  input  logic [31:0] data,
  input  logic        chain_in,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        en_load,
  input  logic        en_load_value,
  output logic [31:0] value,
  output logic        enable,
  output logic        tc
);

  logic        tick;
  logic [31:0] value_next;
  logic        enable_next;

  // Tick/terminal-count decision and next value; bus loads win over counting
  always_comb begin
    // A config write that clears enable stops the tick in the same cycle
    tick        = enable & ~(en_load & ~en_load_value) & (mode_chain ? chain_in : 1'b1);
    tc          = tick & (mode_up ? (value == data) : (value == 32'd0));
    value_next  = value;
    enable_next = enable;
    if (tick) begin
      if (tc) begin
        if (mode_oneshot) enable_next = 1'b0;
        else              value_next  = mode_up ? 32'd0 : data;
      end else begin
        value_next = mode_up ? value + 32'd1 : value - 32'd1;
      end
    end
    if (load)    value_next  = load_value;
    if (en_load) enable_next = en_load_value;
  end

  // Count state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value  <= 32'd0;
      enable <= 1'b0;
    end else begin
      value  <= value_next;
      enable <= enable_next;
    end
  end

endmodule

// File: rtl/counter_timer_chain.sv
// Programmable 32-bit counter/timer on the PicoRV32 iomem bus; two
// instances can be chained through chain_out -> chain_in for 64 bits.
module counter_timer_chain
  import counter_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h2000_0000,
  parameter logic [7:0]  CFG_OFF  = OFF_CFG,
  parameter logic [7:0]  VAL_OFF  = OFF_VAL,
  parameter logic [7:0]  DAT_OFF  = OFF_DAT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        chain_in,
  output logic        chain_out,
  output logic        irq_out
);

  logic [7:0]          offset;
  logic                hit_cfg;
  logic                hit_val;
  logic                hit_dat;
  logic                sel;
  logic                wr;
  logic                cfg_oneshot;
  logic                cfg_up;
  logic                cfg_chain;
  logic                cfg_irqen;
  logic [CFG_BITS-1:0] cfg_new;
  logic [31:0]         cfg_word;
  logic [31:0]         data;
  logic [31:0]         value;
  logic [31:0]         rd_word;
  logic [31:0]         load_value;
  logic                load;
  logic                en_load;
  logic                enable;
  logic                tc;

  // Address decode, read mux and write-merge values
  always_comb begin
    offset  = iomem_addr[7:0];
    hit_cfg = (offset == CFG_OFF);
    hit_val = (offset == VAL_OFF);
    hit_dat = (offset == DAT_OFF);
    // Masking with ready keeps a held request from being accepted twice
    sel     = iomem_valid & (iomem_addr[31:8] == BASE_ADR[31:8]) &
              (hit_cfg | hit_val | hit_dat) & ~iomem_ready;
    wr      = sel & (iomem_wstrb != 4'b0000);

    cfg_word              = 32'd0;
    cfg_word[CFG_EN]      = enable;
    cfg_word[CFG_ONESHOT] = cfg_oneshot;
    cfg_word[CFG_UP]      = cfg_up;
    cfg_word[CFG_CHAIN]   = cfg_chain;
    cfg_word[CFG_IRQEN]   = cfg_irqen;
    // All live config bits sit in byte lane 0
    cfg_new = iomem_wstrb[0] ? iomem_wdata[CFG_BITS-1:0] : cfg_word[CFG_BITS-1:0];

    if (hit_cfg)      rd_word = cfg_word;
    else if (hit_val) rd_word = value;
    else              rd_word = data;

    load       = wr & hit_val;
    load_value = wstrb_merge(value, iomem_wdata, iomem_wstrb);
    en_load    = wr & hit_cfg;
  end

  // Bus acknowledge: one-cycle ready with read data captured at selection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd_word : 32'd0;
    end
  end

  // Mode bits and reload/limit register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_oneshot <= 1'b0;
      cfg_up      <= 1'b0;
      cfg_chain   <= 1'b0;
      cfg_irqen   <= 1'b0;
      data        <= 32'd0;
    end else begin
      if (en_load) begin
        cfg_oneshot <= cfg_new[CFG_ONESHOT];
        cfg_up      <= cfg_new[CFG_UP];
        cfg_chain   <= cfg_new[CFG_CHAIN];
        cfg_irqen   <= cfg_new[CFG_IRQEN];
      end
      if (wr && hit_dat) data <= wstrb_merge(data, iomem_wdata, iomem_wstrb);
    end
  end

  // Terminal-count event pulses, one cycle after the TC tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain_out <= 1'b0;
      irq_out   <= 1'b0;
    end else begin
      chain_out <= tc;
      irq_out   <= tc & cfg_irqen;
    end
  end

  counter_timer_core u_core (
    .clk           (clk),
    .resetn        (resetn),
    .mode_oneshot  (cfg_oneshot),
    .mode_up       (cfg_up),
    .mode_chain    (cfg_chain),
    .data          (data),
    .chain_in      (chain_in),
    .load          (load),
    .load_value    (load_value),
    .en_load       (en_load),
    .en_load_value (cfg_new[CFG_EN]),
    .value         (value),
    .enable        (enable),
    .tc            (tc)
  );

endmodule

// File: tb/tb_counter_timer_chain.sv
// Bench for counter_timer_chain: two chained instances on a shared bus,
// directed scenarios plus random traffic against a cycle-level model.
module tb_counter_timer_chain;

  localparam logic [31:0] LO = 32'h2000_0000;
  localparam logic [31:0] HI = 32'h2000_0100;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        valid  = 1'b0;
  logic [3:0]  wstrb  = 4'h0;
  logic [31:0] addr   = 32'd0;
  logic [31:0] wdata  = 32'd0;
  logic        cin0   = 1'b0;
  logic [1:0]  rdy;
  logic [1:0]  cout;
  logic [1:0]  irq;
  logic [31:0] rd0;
  logic [31:0] rd1;

  int n_cmp = 0;
  int n_bad = 0;
  int co_cnt  [2] = '{0, 0};
  int irq_cnt [2] = '{0, 0};

  // Reference model state
  logic [31:0] bases [2] = '{LO, HI};
  logic [1:0]  m_en, m_os, m_up, m_ch, m_ie, m_rdy, m_co, m_irq;
  logic [31:0] m_val [2];
  logic [31:0] m_dat [2];
  logic [31:0] m_rd  [2];

  always #5 clk = ~clk;

  counter_timer_chain #(.BASE_ADR(LO)) u_lo (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(rdy[0]),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rd0),
    .chain_in(cin0), .chain_out(cout[0]), .irq_out(irq[0])
  );

  counter_timer_chain #(.BASE_ADR(HI)) u_hi (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(rdy[1]),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rd1),
    .chain_in(cout[0]), .chain_out(cout[1]), .irq_out(irq[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_en = '0; m_os = '0; m_up = '0; m_ch = '0; m_ie = '0;
    m_rdy = '0; m_co = '0; m_irq = '0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 32'd0; m_dat[i] = 32'd0; m_rd[i] = 32'd0;
    end
  endtask

  // Reference model: applies the timer rules once per clock edge
  initial begin : model
    logic [7:0]  off;
    logic        sel, wr, tick, tc, cin, old_co0;
    logic [31:0] cw, nc, rw, nv;
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        model_reset();
      end else begin
        old_co0 = m_co[0];
        for (int i = 0; i < 2; i++) begin
          off = addr[7:0];
          sel = valid && (addr[31:8] == bases[i][31:8]) &&
                (off == 8'h00 || off == 8'h04 || off == 8'h08) && !m_rdy[i];
          wr  = sel && (wstrb != 4'h0);
          cw  = {27'd0, m_ie[i], m_ch[i], m_up[i], m_os[i], m_en[i]};
          nc  = merge(cw, wdata, wstrb);
          if (off == 8'h00)      rw = cw;
          else if (off == 8'h04) rw = m_val[i];
          else                   rw = m_dat[i];
          cin  = (i == 0) ? cin0 : old_co0;
          tick = m_en[i] && !(wr && off == 8'h00 && !nc[0]) && (!m_ch[i] || cin);
          tc   = tick && (m_up[i] ? (m_val[i] == m_dat[i]) : (m_val[i] == 32'd0));
          nv   = m_val[i];
          if (tick && !tc)                nv = m_up[i] ? m_val[i] + 1 : m_val[i] - 1;
          else if (tc && !m_os[i])        nv = m_up[i] ? 32'd0 : m_dat[i];
          if (wr && off == 8'h04)         nv = merge(m_val[i], wdata, wstrb);
          m_irq[i] = tc && m_ie[i];
          m_co[i]  = tc;
          if (tc && m_os[i]) m_en[i] = 1'b0;
          if (wr && off == 8'h00) begin
            m_en[i] = nc[0]; m_os[i] = nc[1]; m_up[i] = nc[2]; m_ch[i] = nc[3]; m_ie[i] = nc[4];
          end
          if (wr && off == 8'h08) m_dat[i] = merge(m_dat[i], wdata, wstrb);
          m_val[i] = nv;
          m_rdy[i] = sel;
          m_rd[i]  = sel ? rw : 32'd0;
        end
      end
    end
  end

  // Compare every output of both instances each cycle, tally event pulses
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 32'(rdy[i]), 32'(m_rdy[i]));
      chk($sformatf("rdata%0d", i), (i == 0) ? rd0 : rd1, m_rd[i]);
      chk($sformatf("chain_out%0d", i), 32'(cout[i]), 32'(m_co[i]));
      chk($sformatf("irq_out%0d", i), 32'(irq[i]), 32'(m_irq[i]));
      if (cout[i]) co_cnt[i] <= co_cnt[i] + 1;
      if (irq[i])  irq_cnt[i] <= irq_cnt[i] + 1;
    end
  end

  // Lower timer's carry input toggles randomly; it matters only when chained
  always @(negedge clk) cin0 = 1'($urandom_range(0, 1));

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
    int n;
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rdy[0] | rdy[1]) && n < 8);
    chk("bus_ack", 32'(rdy[0] | rdy[1]), 32'd1);
    r = rdy[0] ? rd0 : rd1;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic unmapped(input logic [31:0] a, input logic [3:0] s);
    @(negedge clk);
    valid = 1'b1; addr = a; wdata = $urandom; wstrb = s;
    repeat (4) @(negedge clk);
    valid = 1'b0; wstrb = 4'h0;
  endtask

  initial begin : stim
    logic [31:0] d, a, v;
    logic [3:0]  s;
    int          s0, s1, inst, o;

    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Reset state readback
    xfer(LO + 0, 0, 4'h0, d); chk("rst_cfg", d, 32'h0);
    xfer(LO + 4, 0, 4'h0, d); chk("rst_val", d, 32'h0);
    xfer(LO + 8, 0, 4'h0, d); chk("rst_dat", d, 32'h0);

    // One-shot down count from 0x19
    xfer(LO + 8, 32'h19, 4'hf, d);
    xfer(LO + 4, 32'h19, 4'hf, d);
    xfer(LO + 0, 32'h03, 4'hf, d);
    #1 s0 = co_cnt[0];
    repeat (40) @(negedge clk);
    #1 chk("oneshot_pulses", co_cnt[0] - s0, 1);
    xfer(LO + 0, 0, 4'h0, d); chk("oneshot_cfg", d, 32'h02);
    xfer(LO + 4, 0, 4'h0, d); chk("oneshot_val", d, 32'h0);

    // Continuous up count, limit 0x0f
    xfer(LO + 0, 0, 4'hf, d);
    xfer(LO + 4, 0, 4'hf, d);
    xfer(LO + 8, 32'h0f, 4'hf, d);
    xfer(LO + 0, 32'h05, 4'hf, d);
    #1 s0 = co_cnt[0];
    repeat (64) @(negedge clk);
    #1 chk("up_wraps", co_cnt[0] - s0, 4);

    // Interrupt on down-count TC with reload
    xfer(LO + 0, 0, 4'hf, d);
    xfer(LO + 8, 32'h12bc, 4'hf, d);
    xfer(LO + 4, 32'h3, 4'hf, d);
    xfer(LO + 0, 32'h11, 4'hf, d);
    #1 s0 = irq_cnt[0];
    repeat (10) @(negedge clk);
    #1 chk("irq_pulses", irq_cnt[0] - s0, 1);
    xfer(LO + 4, 0, 4'h0, d);
    chk("irq_reload", 32'(d <= 32'h12bc && d > 32'h12a0), 1);

    // data = 0 in continuous down mode: TC every tick
    xfer(LO + 0, 0, 4'hf, d);
    xfer(LO + 8, 0, 4'hf, d);
    xfer(LO + 4, 0, 4'hf, d);
    xfer(LO + 0, 32'h01, 4'hf, d);
    #1 s0 = co_cnt[0];
    repeat (10) @(negedge clk);
    #1 chk("zero_data_tc", co_cnt[0] - s0, 10);

    // Up mode starting above the limit wraps through zero
    xfer(LO + 0, 0, 4'hf, d);
    xfer(LO + 8, 32'h5, 4'hf, d);
    xfer(LO + 4, 32'hffff_fffe, 4'hf, d);
    xfer(LO + 0, 32'h05, 4'hf, d);
    #1 s0 = co_cnt[0];
    repeat (12) @(negedge clk);
    #1 chk("up_wrap_tc", co_cnt[0] - s0, 1);

    // Two chained instances
    xfer(LO + 0, 0, 4'hf, d);
    xfer(LO + 8, 32'h3, 4'hf, d);
    xfer(LO + 4, 32'h3, 4'hf, d);
    xfer(HI + 8, 32'h2, 4'hf, d);
    xfer(HI + 4, 32'h2, 4'hf, d);
    xfer(HI + 0, 32'h09, 4'hf, d);
    xfer(LO + 0, 32'h01, 4'hf, d);
    #1 begin s0 = co_cnt[0]; s1 = co_cnt[1]; end
    repeat (40) @(negedge clk);
    #1 begin
      chk("chain_lo_tc", co_cnt[0] - s0, 10);
      chk("chain_hi_tc", co_cnt[1] - s1, 3);
    end

    // Value write while counting, then a single-byte write
    xfer(LO + 4, 32'hdcba_7cfb, 4'hf, d);
    xfer(LO + 4, 0, 4'h0, d);
    chk("val_write", 32'((32'hdcba_7cfb - d) <= 32'd4), 1);
    xfer(LO + 4, 32'h0000_00ff, 4'b0001, d);
    xfer(LO + 4, 0, 4'h0, d);
    chk("byte_write_hi", {8'h0, d[31:8]}, 32'h00dc_ba7c);
    chk("byte_write_lo", 32'(d[7:0] >= 8'hf8), 1);

    // Asynchronous reset in mid-count
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk("async_rst_out", {rd0[15:0] | rd1[15:0], 12'd0, rdy, cout, irq}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    xfer(LO + 0, 0, 4'h0, d); chk("rst2_cfg", d, 32'h0);
    xfer(LO + 4, 0, 4'h0, d); chk("rst2_val", d, 32'h0);
    xfer(HI + 8, 0, 4'h0, d); chk("rst2_hi_dat", d, 32'h0);

    // Random traffic across both instances, including unmapped offsets
    for (int k = 0; k < 300; k++) begin
      inst = $urandom_range(0, 1);
      o    = $urandom_range(0, 3) * 4;
      a    = (inst == 0 ? LO : HI) + 32'(o);
      s    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      if (o == 0)                         v = 32'($urandom_range(0, 31));
      else if ($urandom_range(0, 3) == 0) v = $urandom;
      else                                v = 32'($urandom_range(0, 20));
      if (o == 12) unmapped(a, s);
      else         xfer(a, v, s, d);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
